// File: rtl/mem_issue_fifo.sv
// In-order issue buffer for memory uops feeding the memory execution unit.
// Tracks branch masks per entry and turns mispredicted entries into holes.
module mem_issue_fifo #(
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 6,
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 7 + 10 + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [WIDTH-2:0]     i_instr,
  input  logic                 i_stall,
  input  logic                 i_br_valid,
  input  logic [WIDTH_BRM-1:0] i_br_tag,
  input  logic                 i_br_kill,
  output logic [WIDTH-1:0]     o_instr,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BRM_LO = 4*32 + WIDTH_REG + 7;
  localparam int BRM_HI = BRM_LO + WIDTH_BRM - 1;

  logic [WIDTH-2:0]  payload [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic             br_clear;
  logic             br_kill;
  logic             in_hit;
  logic             accept;
  logic             pop;
  logic             head_valid;
  logic             head_hit;
  logic             out_hit;
  logic [WIDTH-2:0] in_upd;
  logic [WIDTH-2:0] head_upd;

  always_comb begin
    br_clear   = i_br_valid && !i_br_kill;
    br_kill    = i_br_valid && i_br_kill;
    in_hit     = |(i_instr[BRM_HI:BRM_LO] & i_br_tag);
    accept     = i_we && !o_full && !(br_kill && in_hit);
    pop        = !i_stall && (count != '0);
    head_valid = ent_valid[rd_ptr];
    // Kill check on the popped entry uses its brmask before this cycle's update.
    head_hit   = br_kill && |(payload[rd_ptr][BRM_HI:BRM_LO] & i_br_tag);
    out_hit    = br_kill && |(o_instr[BRM_HI:BRM_LO] & i_br_tag);

    in_upd   = i_instr;
    head_upd = payload[rd_ptr];
    if (br_clear) begin
      in_upd[BRM_HI:BRM_LO]   = i_instr[BRM_HI:BRM_LO] & ~i_br_tag;
      head_upd[BRM_HI:BRM_LO] = payload[rd_ptr][BRM_HI:BRM_LO] & ~i_br_tag;
    end
  end

  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);

  // Payload storage carries no reset; occupancy is governed by valid bits and count.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (br_clear)
        payload[i][BRM_HI:BRM_LO] <= payload[i][BRM_HI:BRM_LO] & ~i_br_tag;
    end
    if (accept)
      payload[wr_ptr] <= in_upd;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (br_kill && |(payload[i][BRM_HI:BRM_LO] & i_br_tag))
          ent_valid[i] <= 1'b0;
      end
      if (accept) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_instr <= '0;
    end else if (i_stall) begin
      if (br_clear)
        o_instr[BRM_HI:BRM_LO] <= o_instr[BRM_HI:BRM_LO] & ~i_br_tag;
      if (out_hit)
        o_instr[WIDTH-1] <= 1'b0;
    end else if (pop && head_valid) begin
      o_instr <= {~head_hit, head_upd};
    end else begin
      o_instr <= '0;
    end
  end

endmodule

// File: tb/tb_mem_issue_fifo.sv
// Directed bench for mem_issue_fifo: ordering, full/drop, squash holes,
// branch-mask clearing, kill while stalled and mid-stream reset.
module tb_mem_issue_fifo;

  localparam int W = 159;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_we;
  logic [W-2:0] i_instr;
  logic         i_stall;
  logic         i_br_valid;
  logic [5:0]   i_br_tag;
  logic         i_br_kill;
  logic [W-1:0] o_instr;
  logic         o_full;
  logic         o_empty;

  int errors = 0;
  int checks = 0;

  mem_issue_fifo dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (i_we),
    .i_instr    (i_instr),
    .i_stall    (i_stall),
    .i_br_valid (i_br_valid),
    .i_br_tag   (i_br_tag),
    .i_br_kill  (i_br_kill),
    .o_instr    (o_instr),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Layout {func, brmask, uop, pc, imm, rd, op2, op1}, op1 in the LSBs.
  function automatic logic [W-2:0] mk(input logic [5:0] brm, input logic [6:0] rd,
                                      input logic [31:0] sd);
    return {10'h2A5, brm, 7'b0000011, 32'h1000_0000 + sd, 32'h0000_0100 + sd,
            rd, 32'hBEEF_0000 + sd, 32'hCAFE_0000 + sd};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_we = 1'b0; i_instr = '0; i_stall = 1'b0;
    i_br_valid = 1'b0; i_br_tag = '0; i_br_kill = 1'b0;
    tick(); tick();
    checks++;
    if (o_instr !== '0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", o_instr); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", o_empty); end
    checks++;
    if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", o_full); end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    i_we = 1'b1; i_instr = mk(6'd0, 7'd3, 32'd1); tick();
    i_instr = mk(6'd0, 7'd4, 32'd2); tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'd0, 7'd3, 32'd1)}) begin errors++; $display("[TB] FAIL order_rd3: got %h expected %h", o_instr, {1'b1, mk(6'd0, 7'd3, 32'd1)}); end
    i_instr = mk(6'd0, 7'd5, 32'd3); tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'd0, 7'd4, 32'd2)}) begin errors++; $display("[TB] FAIL order_rd4: got %h expected %h", o_instr, {1'b1, mk(6'd0, 7'd4, 32'd2)}); end
    i_we = 1'b0; tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'd0, 7'd5, 32'd3)}) begin errors++; $display("[TB] FAIL order_rd5: got %h expected %h", o_instr, {1'b1, mk(6'd0, 7'd5, 32'd3)}); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL order_empty: got %b expected 1", o_empty); end
    tick();
    checks++;
    if (o_instr[W-1] !== 1'b0) begin errors++; $display("[TB] FAIL order_idle_valid: got %b expected 0", o_instr[W-1]); end
  endtask

  task automatic test_full_drop();
    i_stall = 1'b1; i_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_instr = mk(6'd0, 7'(10 + i), 32'(100 + i)); tick();
    end
    checks++;
    if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", o_full); end
    i_instr = mk(6'd0, 7'd99, 32'd999); tick();
    checks++;
    if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL full_after_drop: got %b expected 1", o_full); end
    i_we = 1'b0; i_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (o_instr !== {1'b1, mk(6'd0, 7'(10 + i), 32'(100 + i))}) begin errors++; $display("[TB] FAIL drain_%0d: got %h expected %h", i, o_instr, {1'b1, mk(6'd0, 7'(10 + i), 32'(100 + i))}); end
    end
    tick();
    checks++;
    if (o_instr[W-1] !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_valid: got %b expected 0", o_instr[W-1]); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_end_empty: got %b expected 1", o_empty); end
  endtask

  task automatic test_kill_holes();
    i_stall = 1'b1; i_we = 1'b1;
    i_instr = mk(6'b000000, 7'd20, 32'd20); tick();
    i_instr = mk(6'b000010, 7'd21, 32'd21); tick();
    i_instr = mk(6'b000010, 7'd22, 32'd22); tick();
    i_we = 1'b0; i_br_valid = 1'b1; i_br_kill = 1'b1; i_br_tag = 6'b000010; tick();
    i_br_valid = 1'b0; i_br_kill = 1'b0; i_br_tag = '0; i_stall = 1'b0; tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'b000000, 7'd20, 32'd20)}) begin errors++; $display("[TB] FAIL kill_a_issue: got %h expected %h", o_instr, {1'b1, mk(6'b000000, 7'd20, 32'd20)}); end
    tick();
    checks++;
    if (o_instr[W-1] !== 1'b0) begin errors++; $display("[TB] FAIL kill_hole1: got %b expected 0", o_instr[W-1]); end
    checks++;
    if (o_empty !== 1'b0) begin errors++; $display("[TB] FAIL kill_hole1_empty: got %b expected 0", o_empty); end
    tick();
    checks++;
    if (o_instr[W-1] !== 1'b0) begin errors++; $display("[TB] FAIL kill_hole2: got %b expected 0", o_instr[W-1]); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL kill_count_zero: got %b expected 1", o_empty); end
  endtask

  task automatic test_br_clear();
    i_we = 1'b1; i_instr = mk(6'b000100, 7'd30, 32'd30); tick();
    i_we = 1'b0; i_br_valid = 1'b1; i_br_kill = 1'b0; i_br_tag = 6'b000100; tick();
    i_br_valid = 1'b0; i_br_tag = '0;
    checks++;
    if (o_instr !== {1'b1, mk(6'b000000, 7'd30, 32'd30)}) begin errors++; $display("[TB] FAIL clear_issue: got %h expected %h", o_instr, {1'b1, mk(6'b000000, 7'd30, 32'd30)}); end
    tick();
  endtask

  task automatic test_stall_kill();
    i_we = 1'b1; i_instr = mk(6'b000001, 7'd40, 32'd40); tick();
    i_we = 1'b0; tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'b000001, 7'd40, 32'd40)}) begin errors++; $display("[TB] FAIL hold_issue: got %h expected %h", o_instr, {1'b1, mk(6'b000001, 7'd40, 32'd40)}); end
    i_stall = 1'b1; tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'b000001, 7'd40, 32'd40)}) begin errors++; $display("[TB] FAIL hold_stalled: got %h expected %h", o_instr, {1'b1, mk(6'b000001, 7'd40, 32'd40)}); end
    i_br_valid = 1'b1; i_br_kill = 1'b1; i_br_tag = 6'b000001; tick();
    i_br_valid = 1'b0; i_br_kill = 1'b0; i_br_tag = '0;
    checks++;
    if (o_instr !== {1'b0, mk(6'b000001, 7'd40, 32'd40)}) begin errors++; $display("[TB] FAIL hold_killed: got %h expected %h", o_instr, {1'b0, mk(6'b000001, 7'd40, 32'd40)}); end
    i_stall = 1'b0; tick();
  endtask

  task automatic test_mid_reset();
    i_stall = 1'b1; i_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_instr = mk(6'd0, 7'(50 + i), 32'(50 + i)); tick();
    end
    checks++;
    if (o_empty !== 1'b0) begin errors++; $display("[TB] FAIL partial_not_empty: got %b expected 0", o_empty); end
    i_we = 1'b0; i_stall = 1'b0; tick();
    i_rst_n = 1'b0; i_br_valid = 1'b1; i_br_kill = 1'b0; i_br_tag = 6'b000001; tick();
    i_rst_n = 1'b1; i_br_valid = 1'b0; i_br_tag = '0;
    checks++;
    if (o_instr !== '0) begin errors++; $display("[TB] FAIL midrst_instr: got %h expected 0", o_instr); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL midrst_empty: got %b expected 1", o_empty); end
    i_we = 1'b1; i_instr = mk(6'd0, 7'd7, 32'd7); tick();
    i_we = 1'b0; tick();
    checks++;
    if (o_instr !== {1'b1, mk(6'd0, 7'd7, 32'd7)}) begin errors++; $display("[TB] FAIL post_rst_issue: got %h expected %h", o_instr, {1'b1, mk(6'd0, 7'd7, 32'd7)}); end
    tick();
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_empty: got %b expected 1", o_empty); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_drop();
    test_kill_holes();
    test_br_clear();
    test_stall_kill();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
